price_frame_decoder: RTL and testbench

PRICE_FRAME_DECODER -- requirements
Module: price_frame_decoder

---
 rtl/price_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/price_frame_decoder.sv | 141 ++++++++++++++
 tb/tb_price_frame_decoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/price_pkg.sv
// Shared definitions for the price frame decoder.
// Contents:
//   - bit offsets of each field in the 64-bit packed frame
//   - price_entry_t: decoded entry stored in the output FIFO
//   - seq_state_t: states of the sequence tracker
//   - frame_checksum(): XOR of the seven bytes that precede the checksum byte
package price_pkg;

  localparam int unsigned FRAME_W   = 64;

  localparam int unsigned HDR_MSB   = 63;
  localparam int unsigned HDR_LSB   = 56;
  localparam int unsigned TYPE_MSB  = 55;
  localparam int unsigned TYPE_LSB  = 48;
  localparam int unsigned PRICE_MSB = 47;
  localparam int unsigned PRICE_LSB = 16;
  localparam int unsigned SEQ_MSB   = 15;
  localparam int unsigned SEQ_LSB   = 8;
  localparam int unsigned CS_MSB    = 7;
  localparam int unsigned CS_LSB    = 0;

  typedef struct packed {
    logic [31:0] price;
    logic [7:0]  msg_type;
  } price_entry_t;

  localparam int unsigned ENTRY_W = $bits(price_entry_t);

  typedef enum logic {
    SEQ_UNSYNC = 1'b0,
    SEQ_LOCKED = 1'b1
  } seq_state_t;

  function automatic logic [7:0] frame_checksum(input logic [FRAME_W-1:0] f);
    return f[63:56] ^ f[55:48] ^ f[47:40] ^ f[39:32] ^
           f[31:24] ^ f[23:16] ^ f[15:8];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset (pointers/count)
//   i_push, i_data   - write request and data; a write while full is taken
//                      only when a read happens in the same cycle
//   i_pop            - read request; ignored while empty
//   o_data           - head entry (valid while !o_empty)
//   o_full, o_empty  - occupancy flags
//   o_count          - current number of entries
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/price_frame_decoder.sv
// Decodes 64-bit price frames from the UART receiver, validates header and
// checksum, tracks the sequence number and buffers good entries in a FIFO.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   bitstream/frame_valid - incoming frame and its one-cycle strobe
//   price/msg_type        - FIFO head entry, zero while the FIFO is empty
//   out_valid/out_ready   - head-entry handshake
//   err_header, err_checksum, seq_gap, overflow - one-cycle event pulses
//   drop_count            - saturating count of rejected frames
module price_frame_decoder
  import price_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] bitstream,
  input  logic               frame_valid,
  output logic [31:0]        price,
  output logic [7:0]         msg_type,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_header,
  output logic               err_checksum,
  output logic               seq_gap,
  output logic               overflow,
  output logic [15:0]        drop_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic               r_s1_valid;
  logic [FRAME_W-1:0] r_s1_frame;
  seq_state_t         r_state;
  logic [7:0]         r_expected;

  logic               w_hdr_bad;
  logic               w_cs_bad;
  logic               w_good;
  logic               w_rej_hdr;
  logic               w_rej_cs;
  logic               w_pop;
  logic               w_ovf;
  logic               w_reject;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [7:0]         w_seq;
  price_entry_t       w_entry;
  price_entry_t       w_head;

  // Stage 1: capture every strobed frame; evaluated on the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_frame <= '0;
    end else begin
      r_s1_valid <= frame_valid;
      if (frame_valid) begin
        r_s1_frame <= bitstream;
      end
    end
  end

  assign w_hdr_bad = (r_s1_frame[HDR_MSB:HDR_LSB] != HEADER);
  assign w_cs_bad  = (frame_checksum(r_s1_frame) != r_s1_frame[CS_MSB:CS_LSB]);
  // Header error masks a simultaneous checksum error.
  assign w_rej_hdr = r_s1_valid & w_hdr_bad;
  assign w_rej_cs  = r_s1_valid & ~w_hdr_bad & w_cs_bad;
  assign w_good    = r_s1_valid & ~w_hdr_bad & ~w_cs_bad;
  assign w_seq     = r_s1_frame[SEQ_MSB:SEQ_LSB];

  assign w_entry.price    = r_s1_frame[PRICE_MSB:PRICE_LSB];
  assign w_entry.msg_type = r_s1_frame[TYPE_MSB:TYPE_LSB];

  assign w_pop    = ~w_empty & out_ready;
  assign w_ovf    = w_good & w_full & ~w_pop;
  assign w_reject = w_rej_hdr | w_rej_cs | w_ovf;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_good),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // The FIFO storage is not reset, so gate the head with occupancy; this
  // also yields zero outputs throughout reset.
  assign out_valid = ~w_empty;
  assign price     = w_empty ? '0 : w_head.price;
  assign msg_type  = w_empty ? '0 : w_head.msg_type;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_header   <= 1'b0;
      err_checksum <= 1'b0;
      overflow     <= 1'b0;
      drop_count   <= '0;
    end else begin
      err_header   <= w_rej_hdr;
      err_checksum <= w_rej_cs;
      overflow     <= w_ovf;
      if (w_reject && (drop_count != '1)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Sequence tracker: advances on every good frame, including ones the
  // FIFO then drops for overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= SEQ_UNSYNC;
      r_expected <= '0;
      seq_gap    <= 1'b0;
    end else begin
      seq_gap <= 1'b0;
      if (w_good) begin
        r_expected <= w_seq + 8'd1;
        case (r_state)
          SEQ_UNSYNC: r_state <= SEQ_LOCKED;
          SEQ_LOCKED: seq_gap <= (w_seq != r_expected);
          default:    r_state <= SEQ_UNSYNC;
        endcase
      end
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    w_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_price_frame_decoder.sv
module tb_price_frame_decoder;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] bitstream = '0;
  logic        frame_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] price;
  logic [7:0]  msg_type;
  logic        out_valid;
  logic        err_header;
  logic        err_checksum;
  logic        seq_gap;
  logic        overflow;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  price_frame_decoder #(
    .FIFO_DEPTH (DEPTH),
    .HEADER     (8'hA5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bitstream    (bitstream),
    .frame_valid  (frame_valid),
    .price        (price),
    .msg_type     (msg_type),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_header   (err_header),
    .err_checksum (err_checksum),
    .seq_gap      (seq_gap),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] price;
    logic [7:0]  mt;
  } ent_t;

  typedef struct {
    bit          eh;
    bit          ec;
    bit          sg;
    bit          ov;
    bit          vld;
    logic [15:0] drop;
  } cyc_t;

  ent_t        sb[$];   // accepted entries, in delivery order
  cyc_t        cq[$];   // per-cycle expected outputs
  bit          mon_en = 1'b0;

  logic [63:0] m_s1;
  bit          m_s1v;
  bit          m_locked;
  logic [7:0]  m_exp;
  bit          m_eh, m_ec, m_sg, m_ov;
  int          m_drop;
  int          m_occ;

  function automatic logic [7:0] xsum(input logic [63:0] f);
    logic [7:0] x = 8'h00;
    for (int i = 1; i < 8; i++) x ^= 8'(f >> (8 * i));
    return x;
  endfunction

  function automatic logic [63:0] mk(input logic [7:0] h, input logic [7:0] t,
                                     input logic [31:0] p, input logic [7:0] s,
                                     input bit bad_cs);
    logic [63:0] f;
    f = {h, t, p, s, 8'h00};
    f[7:0] = bad_cs ? ~xsum(f) : xsum(f);
    return f;
  endfunction

  task automatic model_reset();
    m_s1v = 0; m_locked = 0; m_exp = 8'h00;
    m_eh = 0; m_ec = 0; m_sg = 0; m_ov = 0;
    m_drop = 0; m_occ = 0;
    sb.delete();
    cq.delete();
  endtask

  task automatic drop_inc();
    if (m_drop < 65535) m_drop++;
  endtask

  // Called once per cycle with that cycle's inputs applied.
  task automatic step();
    cyc_t c;
    bit   pop;
    ent_t e;
    c.eh = m_eh; c.ec = m_ec; c.sg = m_sg; c.ov = m_ov;
    c.vld = (m_occ > 0); c.drop = 16'(m_drop);
    cq.push_back(c);
    pop = (m_occ > 0) && out_ready;
    m_eh = 0; m_ec = 0; m_sg = 0; m_ov = 0;
    if (m_s1v) begin
      if (m_s1[63:56] != 8'hA5) begin
        m_eh = 1; drop_inc();
      end else if (xsum(m_s1) != m_s1[7:0]) begin
        m_ec = 1; drop_inc();
      end else begin
        if (m_locked && (m_s1[15:8] != m_exp)) m_sg = 1;
        m_locked = 1;
        m_exp = m_s1[15:8] + 8'd1;
        if (m_occ < DEPTH || pop) begin
          e.price = m_s1[47:16];
          e.mt    = m_s1[55:48];
          sb.push_back(e);
          m_occ++;
        end else begin
          m_ov = 1; drop_inc();
        end
      end
    end
    if (pop) m_occ--;
    m_s1v = frame_valid;
    if (frame_valid) m_s1 = bitstream;
  endtask

  // ---------------- monitor ----------------
  initial begin
    cyc_t c;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL cq_empty: no expectation queued at %0t", $time);
        end else begin
          c = cq.pop_front();
          chk("out_valid",    64'(out_valid),    64'(c.vld));
          chk("err_header",   64'(err_header),   64'(c.eh));
          chk("err_checksum", 64'(err_checksum), 64'(c.ec));
          chk("seq_gap",      64'(seq_gap),      64'(c.sg));
          chk("overflow",     64'(overflow),     64'(c.ov));
          chk("drop_count",   64'(drop_count),   64'(c.drop));
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL head_unexpected: out_valid with empty scoreboard at %0t", $time);
          end else begin
            chk("price",    64'(price),    64'(sb[0].price));
            chk("msg_type", 64'(msg_type), 64'(sb[0].mt));
            if (out_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input bit fv, input logic [63:0] bs, input bit rdy);
    @(posedge clk);
    #2;
    reset       = 1'b1;
    mon_en      = 1'b1;
    frame_valid = fv;
    bitstream   = bs;
    out_ready   = rdy;
    step();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 64'h0, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    mon_en      = 1'b0;
    reset       = 1'b0;
    frame_valid = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid),  64'd0);
    chk("rst_drop",      64'(drop_count), 64'd0);
    chk("rst_price",     64'(price),      64'd0);
    chk("rst_msg_type",  64'(msg_type),   64'd0);
    chk("rst_events",    64'({err_header, err_checksum, seq_gap, overflow}), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [7:0]  rs;
    int          kind;
    logic [7:0]  h;
    bit          fv;

    model_reset();
    #1;
    chk("init_out_valid", 64'(out_valid),  64'd0);
    chk("init_drop",      64'(drop_count), 64'd0);
    chk("init_price",     64'(price),      64'd0);
    chk("init_events",    64'({err_header, err_checksum, seq_gap, overflow}), 64'd0);
    repeat (3) @(posedge clk);

    // Good frame: visible two cycles after the strobe.
    cycle(1'b1, mk(8'hA5, 8'h01, 32'h0001E240, 8'h00, 1'b0), 1'b1);
    cycle(1'b0, 64'h0, 1'b1);
    chk("t1_valid_early", 64'(out_valid), 64'd0);
    cycle(1'b0, 64'h0, 1'b1);
    chk("t1_valid",  64'(out_valid), 64'd1);
    chk("t1_price",  64'(price),     64'h0001E240);
    chk("t1_type",   64'(msg_type),  64'h01);
    idle(3, 1'b1);

    // Bad header then bad checksum.
    do_reset();
    cycle(1'b1, mk(8'h5A, 8'h02, 32'h11111111, 8'h01, 1'b0), 1'b1);
    cycle(1'b1, mk(8'hA5, 8'h02, 32'h22222222, 8'h02, 1'b1), 1'b1);
    idle(4, 1'b1);
    chk("t2_drop",  64'(drop_count), 64'd2);
    chk("t2_valid", 64'(out_valid),  64'd0);

    // Sequence 07, 08, 0A.
    do_reset();
    cycle(1'b1, mk(8'hA5, 8'h03, 32'h00000007, 8'h07, 1'b0), 1'b1);
    cycle(1'b1, mk(8'hA5, 8'h03, 32'h00000008, 8'h08, 1'b0), 1'b1);
    cycle(1'b1, mk(8'hA5, 8'h03, 32'h0000000A, 8'h0A, 1'b0), 1'b1);
    idle(6, 1'b1);
    chk("t3_drained", 64'(sb.size()), 64'd0);

    // Sequence wrap FF -> 00.
    do_reset();
    cycle(1'b1, mk(8'hA5, 8'h04, 32'hFFFF0000, 8'hFF, 1'b0), 1'b1);
    cycle(1'b1, mk(8'hA5, 8'h04, 32'h0000FFFF, 8'h00, 1'b0), 1'b1);
    idle(5, 1'b1);

    // Overflow: five back-to-back with consumer stalled.
    do_reset();
    for (int i = 0; i < 5; i++)
      cycle(1'b1, mk(8'hA5, 8'(8'h10 + i), 32'(32'hA0000000 + i), 8'(8'h20 + i), 1'b0), 1'b0);
    idle(3, 1'b0);
    chk("t5_drop",  64'(drop_count), 64'd1);
    chk("t5_valid", 64'(out_valid),  64'd1);
    idle(6, 1'b1);
    chk("t5_drained", 64'(sb.size()), 64'd0);

    // Reset with entries buffered.
    do_reset();
    cycle(1'b1, mk(8'h00, 8'h05, 32'h0, 8'h00, 1'b0), 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, mk(8'hA5, 8'h06, 32'(32'hB0 + i), 8'(8'h30 + i), 1'b0), 1'b0);
    idle(3, 1'b0);
    chk("t6_pre_drop", 64'(drop_count), 64'd1);
    do_reset();
    cycle(1'b1, mk(8'hA5, 8'h07, 32'h00000042, 8'h42, 1'b0), 1'b1);
    idle(4, 1'b1);

    // Randomised traffic.
    rs = 8'($urandom);
    for (int n = 0; n < 600; n++) begin
      fv   = ($urandom_range(0, 9) < 7);
      kind = $urandom_range(0, 9);
      h    = (kind == 0) ? (8'hA5 ^ 8'($urandom_range(1, 255))) : 8'hA5;
      if ($urandom_range(0, 9) == 0) rs = 8'($urandom);
      cycle(fv, mk(h, 8'($urandom), $urandom, rs, kind == 1), ($urandom_range(0, 9) < 6));
      if (fv) rs = rs + 8'd1;
    end

    // Drain what remains, bounded.
    for (int n = 0; n < 50 && sb.size() > 0; n++) cycle(1'b0, 64'h0, 1'b1);
    @(negedge clk);
    #1;
    chk("final_drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
